// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the 480x272 RGB LCD raster timing generator.
//  - Default horizontal/vertical timing (in clocks and lines).
//  - t_lcd_pixel: the 6/7/6 RGB pixel word carried on the pixel stream.
//  - sat_inc8: 8-bit saturating increment used by the underrun counter.
package lcd_pkg;

  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_H_FP     = 2;
  localparam int LCD_H_SYNC   = 41;
  localparam int LCD_H_BP     = 2;

  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_V_FP     = 2;
  localparam int LCD_V_SYNC   = 10;
  localparam int LCD_V_BP     = 2;

  typedef struct packed {
    logic [5:0] r;
    logic [6:0] g;
    logic [5:0] b;
  } t_lcd_pixel;

  localparam t_lcd_pixel LCD_BLACK = '{r: 6'd0, g: 7'd0, b: 6'd0};

  // Saturating increment: sticks at 255 instead of wrapping back to 0.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: valid/ready pixel stream from the framebuffer line reader.
//  pixel_valid  producer -> sink  pixel_data holds a pixel
//  pixel_data   producer -> sink  {r[5:0], g[6:0], b[5:0]}
//  pixel_ready  sink -> producer  sink takes pixel_data this cycle if pixel_valid
//  master = line reader (producer), slave = lcd_timing_gen (sink).
interface lcd_timing_gen_if;
  import lcd_pkg::*;

  logic       pixel_valid;
  t_lcd_pixel pixel_data;
  logic       pixel_ready;

  modport master (output pixel_valid, output pixel_data, input pixel_ready);
  modport slave  (input pixel_valid, input pixel_data, output pixel_ready);

endinterface

// File: rtl/lcd_axis_counter.sv
// lcd_axis_counter: one raster axis (horizontal or vertical).
//  Counts 0..TOTAL-1 on inc, wrapping with no gap cycle; clear forces 0.
//  Region order along the axis: active, front porch, sync, back porch.
//  Ports:
//   clk, reset  clock and synchronous active-high reset
//   inc         advance by one position
//   clear       force position to 0 on the next edge (wins over inc)
//   cnt         current position
//   wrap        inc while at the last position (position returns to 0)
//   active      position inside the active region
//   sync        position inside the sync pulse
module lcd_axis_counter #(
  parameter  int ACTIVE = 480,
  parameter  int FP     = 2,
  parameter  int SYNC   = 41,
  parameter  int BP     = 2,
  localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int CNT_W  = $clog2(TOTAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam logic [CNT_W-1:0] ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_s;
  logic             active_s;
  logic             sync_s;

  // Region decode and end-of-axis detection from the current position.
  always_comb begin
    wrap_s   = inc & (cnt_r == LAST);
    active_s = (cnt_r < ACT_END);
    sync_s   = (cnt_r >= SYNC_START) && (cnt_r < SYNC_END);
  end

  // Position counter: reset/clear to 0, otherwise advance and wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO;
    end else if (clear) begin
      cnt_r <= ZERO;
    end else if (inc) begin
      cnt_r <= wrap_s ? ZERO : cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt    = cnt_r;
  assign wrap   = wrap_s;
  assign active = active_s;
  assign sync   = sync_s;

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing generator and pixel-stream sink for the
// 480x272 RGB LCD, running in the 9 MHz pixel-clock domain.
//  Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   enable                0 = timing idle (counters held at 0), 1 = run
//   brightness[7:0]       backlight duty in 1/256 units
//   pix (slave)           valid/ready pixel stream; pixel_ready is combinational
//   frame_start           1-cycle pulse aligned with the first pixel of a frame
//   underrun_count[7:0]   saturating count of active pixels with no data
//   lcd__hsync_n/vsync_n  active-low syncs
//   lcd__display_enable   data enable
//   lcd__red/green/blue   6/7/6 pixel, black when no pixel was taken
//   lcd__backlight        PWM backlight
//  All outputs except pixel_ready are registered, one cycle behind the counters.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_FP     = LCD_H_FP,
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BP     = LCD_H_BP,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_FP     = LCD_V_FP,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BP     = LCD_V_BP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [7:0]             brightness,
  lcd_timing_gen_if.slave        pix,
  output logic                   frame_start,
  output logic [7:0]             underrun_count,
  output logic                   lcd__hsync_n,
  output logic                   lcd__vsync_n,
  output logic                   lcd__display_enable,
  output logic [5:0]             lcd__red,
  output logic [6:0]             lcd__green,
  output logic [5:0]             lcd__blue,
  output logic                   lcd__backlight
);

  localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [H_W-1:0] H_ZERO = {H_W{1'b0}};
  localparam logic [V_W-1:0] V_ZERO = {V_W{1'b0}};

  logic [H_W-1:0] h_cnt_s;
  logic [V_W-1:0] v_cnt_s;
  logic           h_wrap_s;
  logic           h_active_s;
  logic           h_sync_s;
  logic           v_active_s;
  logic           v_sync_s;
  // End of frame is implied by h=0,v=0; the vertical wrap is not needed.
  logic           unused_v_wrap_s;

  logic           ready_s;
  logic           take_s;
  logic           starve_s;
  logic           first_s;

  logic           hsync_n_r;
  logic           vsync_n_r;
  logic           de_r;
  logic           frame_start_r;
  t_lcd_pixel     pixel_r;
  logic [7:0]     underrun_r;
  logic [7:0]     pwm_cnt_r;
  logic           backlight_r;

  // Counters run only while enabled; dropping enable parks them at 0.
  lcd_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .inc    (enable),
    .clear  (!enable),
    .cnt    (h_cnt_s),
    .wrap   (h_wrap_s),
    .active (h_active_s),
    .sync   (h_sync_s)
  );

  lcd_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .inc    (h_wrap_s),
    .clear  (!enable),
    .cnt    (v_cnt_s),
    .wrap   (unused_v_wrap_s),
    .active (v_active_s),
    .sync   (v_sync_s)
  );

  // Handshake decode. ready ignores pixel_valid: a missing pixel is dropped,
  // never waited for, so the raster timing cannot slip.
  always_comb begin
    ready_s  = enable & h_active_s & v_active_s;
    take_s   = ready_s & pix.pixel_valid;
    starve_s = ready_s & ~pix.pixel_valid;
    first_s  = enable & (h_cnt_s == H_ZERO) & (v_cnt_s == V_ZERO);
  end

  assign pix.pixel_ready = ready_s;

  // Raster output stage; syncs are gated by enable so a disable idles them at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_n_r     <= 1'b1;
      vsync_n_r     <= 1'b1;
      de_r          <= 1'b0;
      frame_start_r <= 1'b0;
      pixel_r       <= LCD_BLACK;
    end else begin
      hsync_n_r     <= ~(enable & h_sync_s);
      vsync_n_r     <= ~(enable & v_sync_s);
      de_r          <= ready_s;
      frame_start_r <= first_s;
      pixel_r       <= take_s ? pix.pixel_data : LCD_BLACK;
    end
  end

  // Underrun counter: one count per starved active pixel, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_r <= 8'd0;
    end else if (starve_s) begin
      underrun_r <= sat_inc8(underrun_r);
    end else begin
      underrun_r <= underrun_r;
    end
  end

  // Backlight PWM; free-running regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_r   <= 8'd0;
      backlight_r <= 1'b0;
    end else begin
      pwm_cnt_r   <= pwm_cnt_r + 8'd1;
      backlight_r <= (pwm_cnt_r < brightness);
    end
  end

  assign frame_start         = frame_start_r;
  assign underrun_count      = underrun_r;
  assign lcd__hsync_n        = hsync_n_r;
  assign lcd__vsync_n        = vsync_n_r;
  assign lcd__display_enable = de_r;
  assign lcd__red            = pixel_r.r;
  assign lcd__green          = pixel_r.g;
  assign lcd__blue           = pixel_r.b;
  assign lcd__backlight      = backlight_r;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed bench for lcd_timing_gen.
// Horizontal timing uses the real 525-clock line; the vertical axis is shrunk
// to 4 active / 2 fp / 3 sync / 2 bp lines (11 lines, 5775-clock frame) so
// whole frames fit in a short run.
module tb_lcd_timing_gen;
  import lcd_pkg::*;

  localparam int HT = 525;
  localparam int VT = 11;
  localparam int FT = HT * VT;
  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  brightness;
  logic        frame_start;
  logic [7:0]  underrun_count;
  logic        lcd__hsync_n;
  logic        lcd__vsync_n;
  logic        lcd__display_enable;
  logic [5:0]  lcd__red;
  logic [6:0]  lcd__green;
  logic [5:0]  lcd__blue;
  logic        lcd__backlight;
  logic [18:0] rgb_s;

  lcd_timing_gen_if pix ();

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .V_ACTIVE (4),
    .V_FP     (2),
    .V_SYNC   (3),
    .V_BP     (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .brightness          (brightness),
    .pix                 (pix),
    .frame_start         (frame_start),
    .underrun_count      (underrun_count),
    .lcd__hsync_n        (lcd__hsync_n),
    .lcd__vsync_n        (lcd__vsync_n),
    .lcd__display_enable (lcd__display_enable),
    .lcd__red            (lcd__red),
    .lcd__green          (lcd__green),
    .lcd__blue           (lcd__blue),
    .lcd__backlight      (lcd__backlight)
  );

  assign rgb_s = {lcd__red, lcd__green, lcd__blue};

  typedef struct {
    int          c;      // raster position (v*525+h) counted from frame start
    logic        rdy;    // pixel_ready while at that position
    logic        de;     // registered outputs one cycle later
    logic        hs_n;
    logic        vs_n;
    logic        fs;
    logic [18:0] rgb;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;   // expected position within the frame
  int   abs_n  = 0;   // expected position since the last restart

  // Pixel word presented at a position: {line, column} packed.
  function automatic logic [18:0] pix_of(input int c);
    int h;
    int v;
    h = c % HT;
    v = (c / HT) % VT;
    return 19'((v << 10) | h);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (h=%0d v=%0d)", name, act, exp, n % HT, n / HT);
    end
  endtask

  // One clock; afterwards registered outputs reflect the previous position.
  task automatic step();
    @(posedge clk);
    if (reset || !enable) begin
      n     = 0;
      abs_n = 0;
    end else begin
      abs_n = abs_n + 1;
      n     = abs_n % FT;
    end
    #1;
    pix.pixel_data = pix_of(n);
  endtask

  task automatic goto_pos(input int h, input int v);
    int target;
    int budget;
    target = v * HT + h;
    budget = 2 * FT;
    while (n != target && budget > 0) begin
      step();
      budget--;
    end
    if (n != target) begin
      checks++;
      errors++;
      $display("FAIL goto: got position %0d, expected %0d", n, target);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hs_n"}, 32'(lcd__hsync_n), 32'd1);
    chk({tag, "_vs_n"}, 32'(lcd__vsync_n), 32'd1);
    chk({tag, "_de"},   32'(lcd__display_enable), 32'd0);
    chk({tag, "_rgb"},  32'(rgb_s), 32'd0);
    chk({tag, "_fs"},   32'(frame_start), 32'd0);
  endtask

  initial begin
    int fs_cnt;
    int hs_lo;
    int vs_lo;
    int de_hi;
    int de_rise;
    int run;
    int max_run;
    int hi;
    logic prev_de;
    logic [7:0] bl_levels [3];
    vec_t cur;

    //                 c     rdy   de    hs_n  vs_n  fs    rgb
    vecs[0]  = '{0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'd0};
    vecs[1]  = '{1,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19'd1};
    vecs[2]  = '{479,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19'd479};
    vecs[3]  = '{480,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0};
    vecs[4]  = '{481,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0};
    vecs[5]  = '{482,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'd0};
    vecs[6]  = '{522,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'd0};
    vecs[7]  = '{523,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0};
    vecs[8]  = '{525,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19'd1024};
    vecs[9]  = '{725,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19'd1224};
    vecs[10] = '{2054, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19'd3551};
    vecs[11] = '{2100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0};
    vecs[12] = '{3149, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0};
    vecs[13] = '{3150, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0};
    vecs[14] = '{3632, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0};
    vecs[15] = '{4724, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0};
    vecs[16] = '{4725, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0};
    vecs[17] = '{5774, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0};
    vecs[18] = '{5775, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'd0};
    vecs[19] = '{5776, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19'd1};

    reset           = 1'b1;
    enable          = 1'b1;
    brightness      = 8'd0;
    pix.pixel_valid = 1'b1;
    pix.pixel_data  = pix_of(0);

    // Reset state.
    repeat (3) step();
    chk_idle("rst");
    chk("rst_bl", 32'(lcd__backlight), 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    reset = 1'b0;

    // Table: raster positions across the first frame and the wrap.
    for (int i = 0; i < NV; i++) begin
      cur = vecs[i];
      while (abs_n < cur.c && abs_n < 2 * FT) step();
      chk($sformatf("ready@%0d", cur.c), 32'(pix.pixel_ready), 32'(cur.rdy));
      step();
      chk($sformatf("de@%0d", cur.c),   32'(lcd__display_enable), 32'(cur.de));
      chk($sformatf("hs_n@%0d", cur.c), 32'(lcd__hsync_n), 32'(cur.hs_n));
      chk($sformatf("vs_n@%0d", cur.c), 32'(lcd__vsync_n), 32'(cur.vs_n));
      chk($sformatf("fs@%0d", cur.c),   32'(frame_start), 32'(cur.fs));
      chk($sformatf("rgb@%0d", cur.c),  32'(rgb_s), 32'(cur.rgb));
    end

    // One whole frame of output statistics.
    fs_cnt = 0; hs_lo = 0; vs_lo = 0; de_hi = 0; de_rise = 0; run = 0; max_run = 0;
    prev_de = lcd__display_enable;
    for (int k = 0; k < FT; k++) begin
      step();
      if (frame_start) fs_cnt++;
      if (!lcd__hsync_n) hs_lo++;
      if (!lcd__vsync_n) vs_lo++;
      if (lcd__display_enable) begin
        de_hi++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (lcd__display_enable && !prev_de) de_rise++;
      prev_de = lcd__display_enable;
    end
    chk("frame_fs_pulses", 32'(fs_cnt), 32'd1);
    chk("frame_hsync_low", 32'(hs_lo), 32'd451);
    chk("frame_vsync_low", 32'(vs_lo), 32'd1575);
    chk("frame_de_high", 32'(de_hi), 32'd1920);
    chk("frame_de_lines", 32'(de_rise), 32'd4);
    chk("de_run_length", 32'(max_run), 32'd480);

    // Three starved pixels go out black and are counted.
    goto_pos(10, 0);
    pix.pixel_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("starve_rgb%0d", k), 32'(rgb_s), 32'd0);
    end
    pix.pixel_valid = 1'b1;
    step();
    chk("after_starve_rgb", 32'(rgb_s), 32'd13);
    chk("underrun_3", 32'(underrun_count), 32'd3);

    // No pixel is owed in blanking.
    goto_pos(480, 0);
    pix.pixel_valid = 1'b0;
    repeat (40) step();
    chk("underrun_blank", 32'(underrun_count), 32'd3);

    // Saturation at 255.
    goto_pos(0, 1);
    repeat (251) step();
    chk("underrun_254", 32'(underrun_count), 32'd254);
    step();
    chk("underrun_255", 32'(underrun_count), 32'd255);
    repeat (100) step();
    chk("underrun_sat", 32'(underrun_count), 32'd255);
    pix.pixel_valid = 1'b1;

    // Disable mid-line, then restart from the top of the frame.
    goto_pos(100, 2);
    enable = 1'b0;
    #1;
    chk("dis_ready", 32'(pix.pixel_ready), 32'd0);
    step();
    chk_idle("dis");
    repeat (5) step();
    chk("dis_hold_de", 32'(lcd__display_enable), 32'd0);
    enable = 1'b1;
    #1;
    chk("reen_ready", 32'(pix.pixel_ready), 32'd1);
    step();
    chk("reen_fs", 32'(frame_start), 32'd1);
    chk("reen_de", 32'(lcd__display_enable), 32'd1);
    step();
    chk("reen_fs_once", 32'(frame_start), 32'd0);
    chk("reen_rgb", 32'(rgb_s), 32'd1);
    goto_pos(481, 0);
    step();
    chk("reen_hs_before", 32'(lcd__hsync_n), 32'd1);
    step();
    chk("reen_hs_start", 32'(lcd__hsync_n), 32'd0);

    // Disable inside both sync pulses: syncs release on the next edge.
    goto_pos(500, 6);
    enable = 1'b0;
    step();
    chk_idle("dis_sync");
    enable = 1'b1;

    // Reset mid-frame.
    brightness = 8'd128;
    goto_pos(200, 1);
    reset = 1'b1;
    step();
    chk_idle("mid_rst");
    chk("mid_rst_bl", 32'(lcd__backlight), 32'd0);
    chk("mid_rst_underrun", 32'(underrun_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(pix.pixel_ready), 32'd1);
    step();
    chk("mid_rst_fs", 32'(frame_start), 32'd1);
    chk("mid_rst_de", 32'(lcd__display_enable), 32'd1);
    chk("mid_rst_bl_first", 32'(lcd__backlight), 32'd1);

    // Backlight duty over one full PWM period.
    bl_levels[0] = 8'd0;
    bl_levels[1] = 8'd64;
    bl_levels[2] = 8'd255;
    for (int j = 0; j < 3; j++) begin
      brightness = bl_levels[j];
      step();
      step();
      hi = 0;
      for (int k = 0; k < 256; k++) begin
        step();
        if (lcd__backlight) hi++;
      end
      chk($sformatf("backlight_%0d", bl_levels[j]), 32'(hi), 32'(bl_levels[j]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
